// File: rtl/axis_insert_header_pkg.sv
// Shared types and helpers for the AXI-Stream header inserter.
// Keep masks are MSB-aligned: byte 0 sits at the top of the bus.
package axis_insert_header_pkg;

  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_e;

  function automatic int byte_wd(input int data_wd);
    return data_wd / 8;
  endfunction

  function automatic int cnt_wd(input int byte_w);
    return (byte_w > 1) ? $clog2(byte_w) : 1;
  endfunction

  function automatic logic [MAX_BYTES-1:0] keep_msb(
    input int byte_w,
    input int cnt
  );
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < byte_w && i >= byte_w - cnt) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int keep_popcnt(
    input logic [MAX_BYTES-1:0] k
  );
    int c;
    c = 0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (k[i]) c = c + 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_insert_header_if.sv
// Data, header and output channels of the header inserter.
// slave is the inserter's view, master the source/sink view.
interface axis_insert_header_if
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD = 32
) ();

  localparam int BW = byte_wd(DATA_WD);
  localparam int CW = cnt_wd(BW);

  logic               valid_in;
  logic               ready_in;
  logic [DATA_WD-1:0] data_in;
  logic [BW-1:0]      keep_in;
  logic               last_in;

  logic               valid_insert;
  logic               ready_insert;
  logic [DATA_WD-1:0] data_insert;
  logic [BW-1:0]      keep_insert;
  logic [CW-1:0]      byte_insert_cnt;

  logic               valid_out;
  logic               ready_out;
  logic [DATA_WD-1:0] data_out;
  logic [BW-1:0]      keep_out;
  logic               last_out;

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    input  valid_insert, data_insert,
    input  keep_insert, byte_insert_cnt,
    output ready_insert,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out
  );

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    output valid_insert, data_insert,
    output keep_insert, byte_insert_cnt,
    input  ready_insert,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out
  );

endinterface

// File: rtl/axis_hdr_byte_align.sv
// Byte barrel shifter: merges h residual bytes ahead of a beat
// and returns the low h beat bytes as the next residual.
module axis_hdr_byte_align #(
  parameter int DATA_WD     = 32,
  parameter int BYTE_CNT_WD = 2
) (
  input  logic [DATA_WD-1:0]     i_res,
  input  logic [DATA_WD-1:0]     i_din,
  input  logic [BYTE_CNT_WD-1:0] i_h,
  output logic [DATA_WD-1:0]     o_merged,
  output logic [DATA_WD-1:0]     o_res_nxt
);

  logic [BYTE_CNT_WD+2:0] w_sh;

  assign w_sh = {i_h, 3'b000};

  // Residual bits above byte h fall off the top of the window.
  assign o_merged  = DATA_WD'({i_res, i_din} >> w_sh);
  assign o_res_nxt = i_din & ~({DATA_WD{1'b1}} << w_sh);

endmodule

// File: rtl/axis_insert_header.sv
// AXI-Stream header inserter with a registered output stage.
// AXIS_INSERT_HEADER_ZERO_HDR_EN makes a zero-byte header legal.
module axis_insert_header
  import axis_insert_header_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = byte_wd(DATA_WD),
  parameter int BYTE_CNT_WD  = cnt_wd(DATA_BYTE_WD)
) (
  input logic                 clk,
  input logic                 rst,
  axis_insert_header_if.slave bus
);

  localparam int TOT_WD = BYTE_CNT_WD + 2;
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] DATA = ST_DATA;
  localparam logic [1:0] TAIL = ST_TAIL;

  logic [1:0]              r_state;
  logic [BYTE_CNT_WD-1:0]  r_h;
  logic [BYTE_CNT_WD-1:0]  r_tail;
  logic [DATA_WD-1:0]      r_res;
  logic                    r_valid;
  logic [DATA_WD-1:0]      r_data;
  logic [DATA_BYTE_WD-1:0] r_keep;
  logic                    r_last;

  logic                    w_rdy_out;
  logic                    w_ready_in;
  logic                    w_ready_ins;
  logic                    w_in_fire;
  logic                    w_hdr_ok;
  logic                    w_hdr_fire;
  logic                    w_tail_ld;
  logic                    w_fits;
  logic [TOT_WD-1:0]       w_n;
  logic [TOT_WD-1:0]       w_total;
  logic [DATA_WD-1:0]      w_din;
  logic [DATA_WD-1:0]      w_merged;
  logic [DATA_WD-1:0]      w_res_nxt;
  logic [DATA_WD-1:0]      w_data_nxt;
  logic [DATA_BYTE_WD-1:0] w_keep_nxt;
  logic                    w_last_nxt;

  assign w_rdy_out   = !r_valid || bus.ready_out;
  assign w_ready_in  = !rst && r_state == DATA && w_rdy_out;
  assign w_ready_ins = !rst && r_state == IDLE;
  assign w_in_fire   = bus.valid_in && w_ready_in;
  assign w_tail_ld   = r_state == TAIL && w_rdy_out;

`ifdef AXIS_INSERT_HEADER_ZERO_HDR_EN
  assign w_hdr_ok = 1'b1;
`else
  assign w_hdr_ok = |bus.byte_insert_cnt;
`endif

  assign w_hdr_fire = bus.valid_insert && w_ready_ins && w_hdr_ok;

  assign w_n     = TOT_WD'(keep_popcnt(MAX_BYTES'(bus.keep_in)));
  assign w_total = TOT_WD'(r_h) + w_n;
  assign w_fits  = w_total <= TOT_WD'(DATA_BYTE_WD);
  assign w_din   = (r_state == TAIL) ? '0 : bus.data_in;

  axis_hdr_byte_align #(
    .DATA_WD     (DATA_WD),
    .BYTE_CNT_WD (BYTE_CNT_WD)
  ) u_align (
    .i_res     (r_res),
    .i_din     (w_din),
    .i_h       (r_h),
    .o_merged  (w_merged),
    .o_res_nxt (w_res_nxt)
  );

  always_comb begin
    w_keep_nxt = '1;
    w_last_nxt = 1'b0;
    w_data_nxt = '0;
    if (r_state == TAIL) begin
      w_keep_nxt = DATA_BYTE_WD'(
        keep_msb(DATA_BYTE_WD, int'(r_tail)));
      w_last_nxt = 1'b1;
    end else if (bus.last_in && w_fits) begin
      w_keep_nxt = DATA_BYTE_WD'(
        keep_msb(DATA_BYTE_WD, int'(w_total)));
      w_last_nxt = 1'b1;
    end
    // Bytes outside keep are driven as zero.
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      w_data_nxt[8*i +: 8] =
        w_merged[8*i +: 8] & {8{w_keep_nxt[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_h     <= '0;
      r_tail  <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == IDLE): begin
          if (w_hdr_fire) begin
            r_h     <= bus.byte_insert_cnt;
            r_res   <= bus.data_insert;
            r_state <= DATA;
          end
        end
        (r_state == DATA): begin
          if (w_in_fire) begin
            r_res <= w_res_nxt;
            if (bus.last_in && w_fits) begin
              r_state <= IDLE;
            end else if (bus.last_in) begin
              r_tail  <= BYTE_CNT_WD'(
                w_total - TOT_WD'(DATA_BYTE_WD));
              r_state <= TAIL;
            end
          end
        end
        (r_state == TAIL): begin
          if (w_tail_ld) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_in_fire || w_tail_ld) begin
        r_valid <= 1'b1;
        r_data  <= w_data_nxt;
        r_keep  <= w_keep_nxt;
        r_last  <= w_last_nxt;
      end else if (bus.ready_out) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.ready_in     = w_ready_in;
  assign bus.ready_insert = w_ready_ins;
  assign bus.valid_out    = r_valid;
  assign bus.data_out     = r_data;
  assign bus.keep_out     = r_keep;
  assign bus.last_out     = r_last;

endmodule

// File: tb/tb_axis_insert_header.sv
// Directed and randomized checks for axis_insert_header.
// Expected beats come from hand values or a byte-queue model.
module tb_axis_insert_header;

  localparam int TMO = 2000;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  axis_insert_header_if #(.DATA_WD(32)) bus ();

  axis_insert_header #(.DATA_WD(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int          n_total  = 0;
  int          n_bad    = 0;
  int          n_beats  = 0;
  int          n_pushed = 0;
  int          rdy_mode = 0;
  logic [31:0] pd[256];
  logic [3:0]  pk_last;
  int          pn;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)
      bus.ready_out = 1'b1;
    else if (rdy_mode == 1)
      bus.ready_out = ($urandom_range(0, 9) < 7);
    else
      bus.ready_out = 1'b0;
  end

  logic        prev_stall;
  logic [31:0] prev_d;
  logic [3:0]  prev_k;
  logic        prev_l;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_v", bus.valid_out, 1'b1);
        chk("hold_d", bus.data_out, prev_d);
        chk("hold_k", bus.keep_out, prev_k);
        chk("hold_l", bus.last_out, prev_l);
      end
      if (bus.valid_out && bus.ready_out) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", bus.valid_out, 1'b0);
        end else begin
          exp_t e;
          logic [31:0] m;
          e = exp_q.pop_front();
          m = {{8{e.k[3]}}, {8{e.k[2]}},
               {8{e.k[1]}}, {8{e.k[0]}}};
          chk("out_data", bus.data_out & m, e.d & m);
          chk("out_keep", bus.keep_out, e.k);
          chk("out_last", bus.last_out, e.l);
          n_beats++;
        end
      end
      prev_stall = bus.valid_out && !bus.ready_out;
      prev_d = bus.data_out;
      prev_k = bus.keep_out;
      prev_l = bus.last_out;
    end
  end

  task automatic push_exp(input logic [31:0] d,
                          input logic [3:0] k,
                          input logic l);
    exp_t e;
    e.d = d;
    e.k = k;
    e.l = l;
    exp_q.push_back(e);
    n_pushed++;
  endtask

  task automatic model_pkt(input int h,
                           input logic [31:0] hd);
    logic [7:0] b[$];
    for (int i = h - 1; i >= 0; i--)
      b.push_back(hd[8*i +: 8]);
    for (int j = 0; j < pn; j++) begin
      int nv;
      nv = (j == pn - 1) ? $countones(pk_last) : 4;
      for (int i = 0; i < nv; i++)
        b.push_back(pd[j][31-8*i -: 8]);
    end
    while (b.size() > 0) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = '0;
      k = '0;
      for (int i = 0; i < 4 && b.size() > 0; i++) begin
        d[31-8*i -: 8] = b.pop_front();
        k[3-i] = 1'b1;
      end
      push_exp(d, k, b.size() == 0);
    end
  endtask

  task automatic send_hdr(input int h,
                          input logic [31:0] hd);
    bit ok;
    int t;
    t = 0;
    bus.valid_insert    = 1'b1;
    bus.data_insert     = hd;
    bus.byte_insert_cnt = 2'(h);
    bus.keep_insert     = 4'((1 << h) - 1);
    do begin
      @(negedge clk);
      ok = bus.ready_insert;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < TMO);
    if (!ok) chk("hdr_timeout", ok, 1'b1);
    bus.valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d,
                           input logic [3:0] k,
                           input logic l,
                           input bit gaps);
    bit ok;
    int t;
    t = 0;
    if (gaps) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    bus.valid_in = 1'b1;
    bus.data_in  = d;
    bus.keep_in  = k;
    bus.last_in  = l;
    do begin
      @(negedge clk);
      ok = bus.ready_in;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < TMO);
    if (!ok) chk("beat_timeout", ok, 1'b1);
    bus.valid_in = 1'b0;
  endtask

  task automatic send_pkt(input int h,
                          input logic [31:0] hd,
                          input bit gaps);
    send_hdr(h, hd);
    for (int j = 0; j < pn; j++) begin
      send_beat(pd[j],
                (j == pn - 1) ? pk_last : 4'hF,
                j == pn - 1, gaps);
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] d0;
    rst = 1'b1;
    bus.valid_in        = 1'b0;
    bus.data_in         = '0;
    bus.keep_in         = '0;
    bus.last_in         = 1'b0;
    bus.valid_insert    = 1'b0;
    bus.data_insert     = '0;
    bus.keep_insert     = '0;
    bus.byte_insert_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_last", bus.last_out, 1'b0);
    chk("rst_data", bus.data_out, 32'h0);
    chk("rst_keep", bus.keep_out, 4'h0);
    chk("rst_rdy_in", bus.ready_in, 1'b0);
    chk("rst_rdy_ins", bus.ready_insert, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rdy_ins", bus.ready_insert, 1'b1);
    chk("idle_rdy_in", bus.ready_in, 1'b0);
    @(posedge clk);
    #1;

    push_exp(32'hA1B21122, 4'hF, 1'b0);
    push_exp(32'h33445566, 4'hF, 1'b1);
    pd[0] = 32'h11223344;
    pd[1] = 32'h55667788;
    pn = 2;
    pk_last = 4'b1100;
    send_pkt(2, 32'h0000A1B2, 1'b0);
    wait_drain();

    push_exp(32'hC1C2C3DD, 4'hF, 1'b0);
    push_exp(32'hEEFF0000, 4'b1110, 1'b1);
    pd[0] = 32'hDDEEFF00;
    pn = 1;
    pk_last = 4'hF;
    send_pkt(3, 32'h00C1C2C3, 1'b0);
    wait_drain();

    push_exp(32'hAA990000, 4'b1100, 1'b1);
    pd[0] = 32'h99123456;
    pn = 1;
    pk_last = 4'b1000;
    send_pkt(1, 32'h000000AA, 1'b0);
    wait_drain();

`ifndef AXIS_INSERT_HEADER_ZERO_HDR_EN
    bus.valid_insert    = 1'b1;
    bus.byte_insert_cnt = 2'd0;
    bus.data_insert     = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      chk("zh_rdy_ins", bus.ready_insert, 1'b1);
      chk("zh_rdy_in", bus.ready_in, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.valid_insert = 1'b0;
`endif

    for (int j = 0; j < 6; j++) pd[j] = $urandom;
    pn = 6;
    pk_last = 4'b1110;
    model_pkt(2, 32'h5A5A1357);
    fork
      send_pkt(2, 32'h5A5A1357, 1'b0);
      begin
        int t;
        repeat (3) @(posedge clk);
        rdy_mode = 2;
        @(posedge clk);
        #1;
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!bus.valid_out && t < 20);
        d0 = bus.data_out;
        repeat (5) begin
          chk("stall_v", bus.valid_out, 1'b1);
          chk("stall_d", bus.data_out, d0);
          chk("stall_rdy_in", bus.ready_in, 1'b0);
          @(negedge clk);
        end
        rdy_mode = 0;
      end
    join
    wait_drain();

    rdy_mode = 1;
    for (int p = 0; p < 200; p++) begin
      int h;
      int nl;
      logic [31:0] hd;
      h  = $urandom_range(1, 3);
      hd = $urandom;
      if ($urandom_range(0, 9) == 0)
        pn = $urandom_range(1, 256);
      else
        pn = $urandom_range(1, 8);
      for (int j = 0; j < pn; j++) pd[j] = $urandom;
      nl = $urandom_range(1, 4);
      pk_last = 4'(4'hF << (4 - nl));
      model_pkt(h, hd);
      send_pkt(h, hd, 1'b1);
    end
    rdy_mode = 0;
    wait_drain();

    rdy_mode = 2;
    @(posedge clk);
    #1;
    send_hdr(2, 32'h0000BEEF);
    send_beat(32'h01020304, 4'hF, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rdy_in", bus.ready_in, 1'b0);
    chk("mrst_rdy_ins", bus.ready_insert, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mrst_valid", bus.valid_out, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    push_exp(32'h77102030, 4'hF, 1'b0);
    push_exp(32'h40500000, 4'b1100, 1'b1);
    pd[0] = 32'h10203040;
    pd[1] = 32'h50000000;
    pn = 2;
    pk_last = 4'b1000;
    send_pkt(1, 32'h00000077, 1'b0);
    wait_drain();

    chk("beat_count", n_beats, n_pushed);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
